// File: rtl/rd_port_arbiter.sv
// Round-robin arbiter sharing one async-FIFO read port among several read-domain consumers.
// Grants bounded bursts, gates the read enable and routes the delayed read-valid to the issuer.
module rd_port_arbiter #(
  parameter int P_NUM_REQ = 4,
  parameter int P_ID_W    = 2,
  parameter int P_BURST_W = 4,
  parameter int P_TO_W    = 4,
  parameter int P_RD_LAT  = 1
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic [P_NUM_REQ-1:0] i_req,
  input  logic [P_NUM_REQ-1:0] i_ready,
  input  logic [P_BURST_W-1:0] i_burst_len,
  input  logic [P_TO_W-1:0]    i_timeout,
  input  logic                 i_empty,
  output logic                 o_r_en,
  output logic [P_NUM_REQ-1:0] o_gnt,
  output logic [P_ID_W-1:0]    o_gnt_id,
  output logic [P_NUM_REQ-1:0] o_rvalid,
  output logic                 o_busy
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;

  state_t               state_q;
  logic [P_ID_W-1:0]    last_q;
  logic [P_ID_W-1:0]    owner_q;
  logic [P_NUM_REQ-1:0] gnt_q;
  logic [P_BURST_W-1:0] bcnt_q;
  logic [P_BURST_W-1:0] bcnt_d;
  logic [P_TO_W-1:0]    to_q;
  logic [P_TO_W-1:0]    to_d;
  logic [P_RD_LAT-1:0]  pipe_en_q;
  logic [P_ID_W-1:0]    pipe_id_q [P_RD_LAT];

  logic                 pick_vld_s;
  logic [P_ID_W-1:0]    pick_id_s;
  logic [P_ID_W-1:0]    cand_s;
  logic                 hit_s;
  logic                 owner_req_s;
  logic                 owner_rdy_s;
  logic                 busy_s;
  logic                 end_s;

  // Next owner: first requester searching upward from the one after the last owner.
  always_comb begin
    pick_vld_s = 1'b0;
    pick_id_s  = '0;
    cand_s     = '0;
    hit_s      = 1'b0;
    for (int k = 1; k <= P_NUM_REQ; k++) begin
      cand_s     = P_ID_W'((int'(last_q) + k) % P_NUM_REQ);
      hit_s      = !pick_vld_s && i_req[cand_s];
      pick_id_s  = hit_s ? cand_s : pick_id_s;
      pick_vld_s = pick_vld_s | hit_s;
    end
  end

  assign busy_s      = (state_q == ST_BURST);
  assign owner_req_s = i_req[owner_q];
  assign owner_rdy_s = i_ready[owner_q];
  assign o_r_en      = busy_s & owner_req_s & owner_rdy_s & ~i_empty & (bcnt_q != '0);
  assign bcnt_d      = bcnt_q - P_BURST_W'(o_r_en);
  assign end_s       = (o_r_en && (bcnt_q == P_BURST_W'(1))) || !owner_req_s ||
                       ((i_timeout != '0) && (to_q >= i_timeout));

  // Empty-timeout counter: cleared by data, counts starved cycles, saturates.
  always_comb begin
    to_d = to_q;
    if (i_empty == 1'b0) begin
      to_d = '0;
    end else if (owner_req_s && (to_q != '1)) begin
      to_d = to_q + P_TO_W'(1);
    end else begin
      to_d = to_q;
    end
  end

  // Grant FSM with registered grant, owner index and burst/timeout counters.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_q <= ST_IDLE;
      last_q  <= P_ID_W'(P_NUM_REQ - 1);
      owner_q <= '0;
      gnt_q   <= '0;
      bcnt_q  <= '0;
      to_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_vld_s) begin
            state_q <= ST_BURST;
            owner_q <= pick_id_s;
            gnt_q   <= P_NUM_REQ'(1'b1) << pick_id_s;
            bcnt_q  <= (i_burst_len == '0) ? P_BURST_W'(1) : i_burst_len;
            to_q    <= '0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_BURST: begin
          bcnt_q <= bcnt_d;
          to_q   <= to_d;
          if (end_s) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            last_q  <= owner_q;
          end else begin
            state_q <= ST_BURST;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  // Read-valid pipeline: remembers who issued each read so data follows the issuer.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      pipe_en_q <= '0;
      for (int i = 0; i < P_RD_LAT; i++) begin
        pipe_id_q[i] <= '0;
      end
    end else begin
      pipe_en_q[0] <= o_r_en;
      pipe_id_q[0] <= owner_q;
      for (int i = P_RD_LAT - 1; i > 0; i--) begin
        pipe_en_q[i] <= pipe_en_q[i-1];
        pipe_id_q[i] <= pipe_id_q[i-1];
      end
    end
  end

  assign o_rvalid = P_NUM_REQ'(pipe_en_q[P_RD_LAT-1]) << pipe_id_q[P_RD_LAT-1];
  assign o_gnt    = gnt_q;
  assign o_gnt_id = owner_q;
  assign o_busy   = busy_s;

endmodule

// File: tb/tb_rd_port_arbiter.sv
// Directed bench for rd_port_arbiter: cycle model compared every cycle plus literal scenario checks.
module tb_rd_port_arbiter;
  localparam int N   = 4;
  localparam int LAT = 1;

  logic         rclk = 1'b0;
  logic         rrst = 1'b1;
  logic [N-1:0] i_req = '0;
  logic [N-1:0] i_ready = '1;
  logic [3:0]   i_burst_len = 4'd0;
  logic [3:0]   i_timeout = 4'd0;
  logic         i_empty = 1'b0;
  logic         o_r_en;
  logic [N-1:0] o_gnt;
  logic [1:0]   o_gnt_id;
  logic [N-1:0] o_rvalid;
  logic         o_busy;

  int n_checks = 0;
  int n_err = 0;

  rd_port_arbiter #(.P_NUM_REQ(N), .P_ID_W(2), .P_BURST_W(4), .P_TO_W(4), .P_RD_LAT(LAT)) dut (
    .rclk(rclk), .rrst(rrst), .i_req(i_req), .i_ready(i_ready),
    .i_burst_len(i_burst_len), .i_timeout(i_timeout), .i_empty(i_empty),
    .o_r_en(o_r_en), .o_gnt(o_gnt), .o_gnt_id(o_gnt_id), .o_rvalid(o_rvalid), .o_busy(o_busy)
  );

  always #5 rclk = ~rclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: owner (-1 when idle), reads left, starved cycles, latency queue of issuer ids.
  int m_owner, m_last, m_left, m_to, m_c;
  bit m_ren, m_fin, m_found;
  int m_pipe[$];

  task automatic m_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_left  = 0;
    m_to    = 0;
    m_pipe.delete();
    for (int i = 0; i < LAT; i++) m_pipe.push_back(-1);
  endtask

  function automatic bit m_read_now();
    if (m_owner < 0) return 1'b0;
    return i_req[m_owner] && i_ready[m_owner] && !i_empty && (m_left > 0);
  endfunction

  always @(posedge rclk) begin
    if (rrst) begin
      m_reset();
    end else begin
      m_ren = m_read_now();
      m_pipe.push_back(m_ren ? m_owner : -1);
      void'(m_pipe.pop_front());
      if (m_owner < 0) begin
        m_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          m_c = (m_last + k) % N;
          if (!m_found && i_req[m_c]) begin
            m_found = 1'b1;
            m_owner = m_c;
          end
        end
        if (m_found) begin
          m_left = (i_burst_len == 0) ? 1 : int'(i_burst_len);
          m_to   = 0;
        end
      end else begin
        m_fin = (m_ren && m_left == 1) || !i_req[m_owner] ||
                (i_timeout != 0 && m_to >= int'(i_timeout));
        if (!i_empty) m_to = 0;
        else if (i_req[m_owner] && m_to < 15) m_to = m_to + 1;
        if (m_ren) m_left = m_left - 1;
        if (m_fin) begin
          m_last  = m_owner;
          m_owner = -1;
        end
      end
    end
  end

  // Observed-activity counters for the literal scenario checks.
  int n_ren, n_busy;
  int rv_cnt[N];
  int gq[$];
  logic [N-1:0] prev_gnt = '0;

  task automatic clear_counts();
    n_ren = 0;
    n_busy = 0;
    for (int i = 0; i < N; i++) rv_cnt[i] = 0;
    gq.delete();
  endtask

  always @(negedge rclk) begin
    if (rrst) m_reset();
    check("gnt", 32'(o_gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    check("busy", 32'(o_busy), (m_owner >= 0) ? 32'd1 : 32'd0);
    check("r_en", 32'(o_r_en), 32'(m_read_now()));
    check("rvalid", 32'(o_rvalid), (m_pipe[0] >= 0) ? (32'd1 << m_pipe[0]) : 32'd0);
    if (m_owner >= 0) check("gnt_id", 32'(o_gnt_id), 32'(m_owner));
    if (o_r_en) n_ren++;
    if (o_busy) n_busy++;
    for (int i = 0; i < N; i++) rv_cnt[i] += int'(o_rvalid[i]);
    if (o_gnt != '0 && prev_gnt == '0) gq.push_back(int'(o_gnt_id));
    prev_gnt = o_gnt;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge rclk);
      #1;
    end
  endtask

  task automatic check_order(input string name, input int exp[$]);
    check({name, "_n"}, 32'(gq.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      check(name, (i < gq.size()) ? 32'(gq[i]) : 32'hdead, 32'(exp[i]));
  endtask

  initial begin
    m_reset();
    clear_counts();
    tick(2);
    check("rst_gnt", 32'(o_gnt), 32'd0);
    check("rst_rvalid", 32'(o_rvalid), 32'd0);
    check("rst_ren_busy", {30'd0, o_r_en, o_busy}, 32'd0);
    rrst = 1'b0;
    tick(1);

    // Single requester, three-read burst.
    clear_counts();
    i_req = 4'b0001; i_burst_len = 4'd3; i_empty = 1'b0; i_ready = 4'b1111;
    tick(4);
    i_req = 4'b0000;
    tick(4);
    check("t1_ren", 32'(n_ren), 32'd3);
    check("t1_rv0", 32'(rv_cnt[0]), 32'd3);
    check_order("t1_order", '{0});

    // Everyone requesting, burst of two: full rotation from consumer 0.
    rrst = 1'b1; tick(1); rrst = 1'b0;
    clear_counts();
    i_req = 4'b1111; i_burst_len = 4'd2;
    tick(15);
    i_req = 4'b0000;
    tick(4);
    check("t2_ren", 32'(n_ren), 32'd10);
    check("t2_rv0", 32'(rv_cnt[0]), 32'd4);
    check("t2_rv3", 32'(rv_cnt[3]), 32'd2);
    check_order("t2_order", '{0, 1, 2, 3, 0});

    // Owner 2 starved by an empty FIFO until the timeout releases it; 3 follows.
    clear_counts();
    i_req = 4'b1100; i_burst_len = 4'd4; i_empty = 1'b1; i_timeout = 4'd4;
    tick(6);
    check("t3_busy", 32'(n_busy), 32'd5);
    check("t3_ren_empty", 32'(n_ren), 32'd0);
    check_order("t3_order_a", '{2});
    clear_counts();
    i_empty = 1'b0; i_req = 4'b1000;
    tick(5);
    i_req = 4'b0000;
    tick(3);
    check("t3_ren", 32'(n_ren), 32'd4);
    check_order("t3_order_b", '{3});
    i_timeout = 4'd0;

    // Owner 1 with alternating ready: eight reads spread over the burst.
    clear_counts();
    i_req = 4'b0010; i_burst_len = 4'd8; i_ready = 4'b1101;
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      i_ready[1] = (k % 2 == 1);
    end
    i_req = 4'b0000; i_ready = 4'b1111;
    tick(3);
    check("t4_ren", 32'(n_ren), 32'd8);
    check("t4_busy", 32'(n_busy), 32'd15);
    check("t4_rv1", 32'(rv_cnt[1]), 32'd8);

    // Owner 0 drops its request mid-burst; pending data still reaches it, then 2 is served.
    clear_counts();
    i_req = 4'b0001; i_burst_len = 4'd5;
    tick(3);
    i_req = 4'b0100;
    tick(7);
    i_req = 4'b0000;
    tick(3);
    check("t5_rv0", 32'(rv_cnt[0]), 32'd2);
    check("t5_rv2", 32'(rv_cnt[2]), 32'd5);
    check("t5_ren", 32'(n_ren), 32'd7);
    check_order("t5_order", '{0, 2});

    // Reset asserted between edges in the middle of a burst.
    i_req = 4'b1111; i_burst_len = 4'd8;
    tick(3);
    rrst = 1'b1;
    #2;
    check("t6_gnt", 32'(o_gnt), 32'd0);
    check("t6_ren", 32'(o_r_en), 32'd0);
    check("t6_rvalid", 32'(o_rvalid), 32'd0);
    tick(1);
    rrst = 1'b0;
    clear_counts();
    tick(2);
    check("t6_first", (gq.size() > 0) ? 32'(gq[0]) : 32'hdead, 32'd0);
    i_req = 4'b0000;
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
